alu_nibble_sequencer: RTL and testbench

- Initiator and collector for the 4-bit ALU slice valid-pipeline interface.
- Accepts one WIDTH-bit logic operation per valid/ready request.
- Splits the operands into 4-bit nibbles, LSB first, and issues one nibble per cycle to a single external slice.
- Reassembles the returned nibbles in order and presents the WIDTH-bit result on a valid/ready response port.
- Sits between the datapath controller and one slice instance. This lets a narrow slice serve wide operands.

---
 rtl/alu_nibble_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// Drives a 4-bit ALU slice one nibble per cycle, LSB first, and reassembles the returned nibbles
// into a WIDTH-bit result presented on a valid/ready response port.
module alu_nibble_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic             slc_v_in,
    output logic [3:0]       slc_a,
    output logic [3:0]       slc_b,
    output logic             slc_do_and,
    output logic             slc_do_or,
    output logic             slc_do_xor,
    output logic             slc_do_not,
    output logic             slc_do_pass,
    input  logic [3:0]       slc_result,
    input  logic             slc_v_out,
    output logic             busy
);
    localparam int unsigned NIB    = WIDTH / 4;
    localparam int unsigned CntW   = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned TmrW   = $clog2(NIB + TIMEOUT + 1);
    localparam logic [CntW-1:0] LastNib = CntW'(NIB - 1);
    localparam logic [TmrW-1:0] LastTmr = TmrW'(NIB + TIMEOUT - 1);

    localparam logic [2:0] OpAnd  = 3'd0;
    localparam logic [2:0] OpOr   = 3'd1;
    localparam logic [2:0] OpXor  = 3'd2;
    localparam logic [2:0] OpNot  = 3'd3;
    localparam logic [2:0] OpPass = 3'd4;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   beat_q, beat_d;
    logic [CntW-1:0]   col_q, col_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;

    logic active;
    logic collect;
    logic all_in;
    logic expired;

    assign active  = (state_q == StIssue) || (state_q == StDrain);
    assign collect = active && slc_v_out;
    assign all_in  = collect && (col_q == LastNib);
    assign expired = (tmr_q == LastTmr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            col_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
            col_q   <= col_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        beat_d  = beat_q;
        col_d   = col_q;
        tmr_d   = tmr_q;

        // Results are placed by arrival count, independent of slice latency.
        if (collect) begin
            col_d = col_q + CntW'(1);
            for (int unsigned k = 0; k < NIB; k++) begin
                if (col_q == CntW'(k)) begin
                    res_d[4*k +: 4] = slc_result;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d   = req_op;
                    a_d    = req_a;
                    b_d    = req_b;
                    res_d  = '0;
                    beat_d = '0;
                    col_d  = '0;
                    tmr_d  = '0;
                    if (req_op <= OpPass) begin
                        err_d   = 1'b0;
                        state_d = StIssue;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StIssue: begin
                // Operand registers shift so the current beat always sits in the low nibble.
                a_d    = a_q >> 4;
                b_d    = b_q >> 4;
                beat_d = beat_q + CntW'(1);
                tmr_d  = tmr_q + TmrW'(1);
                if (all_in) begin
                    state_d = StDone;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (beat_q == LastNib) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                tmr_d = tmr_q + TmrW'(1);
                if (all_in) begin
                    state_d = StDone;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign slc_v_in    = (state_q == StIssue);
    assign slc_a       = slc_v_in ? a_q[3:0] : 4'h0;
    assign slc_b       = slc_v_in ? b_q[3:0] : 4'h0;
    assign slc_do_and  = active && (op_q == OpAnd);
    assign slc_do_or   = active && (op_q == OpOr);
    assign slc_do_xor  = active && (op_q == OpXor);
    assign slc_do_not  = active && (op_q == OpNot);
    assign slc_do_pass = active && (op_q == OpPass);
    assign rsp_valid   = (state_q == StDone);
    assign rsp_err     = rsp_valid && err_q;
    assign rsp_result  = (rsp_valid && !err_q) ? res_q : '0;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench: a 2-cycle slice model plus a word-level reference of each operation.
module tb_alu_nibble_sequencer;
    localparam int W   = 16;
    localparam int TO  = 15;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_op = 3'd0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic         rsp_err;
    logic         slc_v_in;
    logic [3:0]   slc_a, slc_b;
    logic         slc_do_and, slc_do_or, slc_do_xor, slc_do_not, slc_do_pass;
    logic [3:0]   slc_result;
    logic         slc_v_out;
    logic         busy;

    alu_nibble_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .slc_v_in   (slc_v_in),
        .slc_a      (slc_a),
        .slc_b      (slc_b),
        .slc_do_and (slc_do_and),
        .slc_do_or  (slc_do_or),
        .slc_do_xor (slc_do_xor),
        .slc_do_not (slc_do_not),
        .slc_do_pass(slc_do_pass),
        .slc_result (slc_result),
        .slc_v_out  (slc_v_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Slice model: capture on issue, apply the op select one cycle later, present one cycle after.
    logic       s1_v = 1'b0, s2_v = 1'b0;
    logic [3:0] s1_a = 4'h0, s1_b = 4'h0, s2_r = 4'h0;
    int         in_idx = 0, s1_idx = 0, s2_idx = 0;
    logic       drop4 = 1'b0;
    logic       stray_v = 1'b0;
    logic [4:0] sel;

    assign sel = {slc_do_pass, slc_do_not, slc_do_xor, slc_do_or, slc_do_and};

    function automatic logic [3:0] slice_op(input logic [4:0] s, input logic [3:0] a,
                                            input logic [3:0] b);
        case (s)
            5'b00001: return a & b;
            5'b00010: return a | b;
            5'b00100: return a ^ b;
            5'b01000: return ~a;
            5'b10000: return a;
            default:  return 4'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        s1_v   <= slc_v_in;
        s1_a   <= slc_a;
        s1_b   <= slc_b;
        s1_idx <= in_idx;
        in_idx <= busy ? in_idx + (slc_v_in ? 1 : 0) : 0;
        s2_v   <= s1_v;
        s2_r   <= slice_op(sel, s1_a, s1_b);
        s2_idx <= s1_idx;
    end

    assign slc_v_out  = (s2_v && !(drop4 && s2_idx == 3)) || stray_v;
    assign slc_result = stray_v ? 4'hF : s2_r;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~a;
            3'd4:    return a;
            default: return '0;
        endcase
    endfunction

    // Called one time unit after a clock edge with the DUT idle.
    task automatic run_txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, input bit stray_in_done);
        bit           legal;
        bit           exp_err;
        logic [W-1:0] exp_res;
        logic [4:0]   exp_sel;
        int           exp_lat;
        int           cyc, beats, first, nib_bad, sel_bad, rdy_bad, busy_bad, hold_bad;
        logic [W-1:0] r;
        logic         e;

        legal   = (op <= 3'd4);
        exp_err = !legal || drop4;
        exp_res = exp_err ? '0 : ref_op(op, a, b);
        exp_sel = legal ? (5'b00001 << op) : 5'b00000;
        exp_lat = !legal ? 1 : (drop4 ? NIB + TO + 1 : NIB + 3);

        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = W'($urandom);
        req_b     = W'($urandom);

        cyc = 1; beats = 0; first = 0; nib_bad = 0; sel_bad = 0; rdy_bad = 0; busy_bad = 0;
        while (rsp_valid !== 1'b1 && cyc < 60) begin
            if (slc_v_in === 1'b1) begin
                if (beats == 0) first = cyc;
                if (beats < NIB && (slc_a !== a[4*beats +: 4] || slc_b !== b[4*beats +: 4]))
                    nib_bad++;
                beats++;
            end
            if (sel !== exp_sel) sel_bad++;
            if (req_ready !== 1'b0) rdy_bad++;
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            cyc++;
        end

        chk("latency", cyc, exp_lat);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_err", rsp_err, exp_err);
        chk("issue_beats", beats, legal ? NIB : 0);
        if (legal) chk("first_issue_cycle", first, 1);
        chk("nibble_order", nib_bad, 0);
        chk("op_select_window", sel_bad, 0);
        chk("req_ready_while_busy", rdy_bad, 0);
        chk("busy_while_active", busy_bad, 0);
        chk("op_select_done", sel, 0);
        chk("slc_v_in_done", slc_v_in, 0);
        chk("req_ready_done", req_ready, 0);

        r = rsp_result;
        e = rsp_err;
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (stray_in_done && i == 0) stray_v = 1'b1;
            @(posedge clk); #1;
            stray_v = 1'b0;
            if (rsp_valid !== 1'b1 || rsp_result !== r || rsp_err !== e ||
                req_ready !== 1'b0 || busy !== 1'b1)
                hold_bad++;
        end
        if (hold > 0) chk("done_hold_stable", hold_bad, 0);

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", rsp_valid, 0);
        chk("req_ready_after_hs", req_ready, 1);
        chk("busy_after_hs", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_slc_v_in", slc_v_in, 0);
        chk("rst_sel", sel, 0);
        chk("rst_slc_ab", {slc_a, slc_b}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(3'd0, 16'h1234, 16'h0F0F, 0, 0);
        run_txn(3'd2, 16'hFFFF, 16'h1234, 0, 0);
        run_txn(3'd3, 16'h00F0, 16'hABCD, 0, 0);
        run_txn(3'd5, 16'h1357, 16'h2468, 0, 0);
        run_txn(3'd1, W'($urandom), W'($urandom), 5, 0);

        // Lost fourth result: timeout, then stray results in DONE and IDLE are ignored.
        drop4 = 1'b1;
        run_txn(3'd0, 16'h5A5A, 16'hFFFF, 3, 1);
        drop4 = 1'b0;
        stray_v = 1'b1;
        @(posedge clk); #1;
        stray_v = 1'b0;
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_rsp_valid", rsp_valid, 0);
        run_txn(3'd4, 16'hC3C3, 16'h0000, 0, 0);

        // Reset while draining; in-flight slice results arrive afterwards.
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("drain_busy", busy, 1);
        chk("drain_slc_v_in", slc_v_in, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("post_rst_busy", busy, 0);
            chk("post_rst_rsp_valid", rsp_valid, 0);
        end
        run_txn(3'd1, 16'hA0A0, 16'h0505, 0, 0);

        for (int n = 0; n < 20; n++) begin
            run_txn(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                    $urandom_range(0, 2), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
